hex_display_scanner: RTL and testbench

- Time-multiplexes a multi-digit hex value onto one shared seven-segment bus.
- Sits directly upstream of the hex-to-seven-segment decoder. Each refresh slot it presents one 4-bit nibble on `nibble`, which the decoder consumes combinationally.
- It also drives the active-low digit anodes and decimal point, inserting a dead interval between digits to prevent ghosting.

---
 rtl/display_pkg.sv | 13 +
 rtl/refresh_prescaler.sv | 39 +++
 rtl/hex_display_scanner.sv | 106 ++++++++++
 tb/tb_hex_display_scanner.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed hex display scanner.
package display_pkg;

  typedef enum logic {
    DEAD  = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  localparam int MAX_DIGITS = 8;
  localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;
  localparam logic SEG_OFF = 1'b1;

endpackage

// File: rtl/refresh_prescaler.sv
// Slot timer: counts 0..REFRESH_DIV-1 while enabled and flags the dead-interval end
// and the slot terminal count. Restarts from 0 when enable returns.
module refresh_prescaler #(
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 500
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic tc,
  output logic dead_end
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] DE_VAL = CNT_W'(DEAD_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_eff;
  logic             resume;

  // The held count is kept while disabled but ignored on the first enabled cycle.
  assign cnt_eff  = resume ? '0 : cnt;
  assign tc       = enable && (cnt_eff == TC_VAL);
  assign dead_end = enable && (cnt_eff == DE_VAL);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      resume <= 1'b0;
    end else begin
      resume <= ~enable;
      if (enable) begin
        cnt <= tc ? '0 : cnt_eff + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/hex_display_scanner.sv
// Scans a shadowed multi-digit hex value onto one seven-segment bus with
// active-low anodes, a dead interval per slot and optional leading-zero blanking.
module hex_display_scanner
  import display_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int REFRESH_DIV   = 50000,
  parameter int DEAD_CYCLES   = 500,
  parameter int BLANK_LEADING = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic                          load,
  input  logic [4*NUM_DIGITS-1:0]       value,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  output logic [3:0]                    nibble,
  output logic [NUM_DIGITS-1:0]         anode_n,
  output logic                          dp_n,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] ANODES_OFF = ANODE_OFF[NUM_DIGITS-1:0];
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic [NUM_DIGITS-1:0][3:0] shadow_val;
  logic [NUM_DIGITS-1:0]      shadow_dp;
  logic [NUM_DIGITS:0]        nz_at_or_above;
  logic [NUM_DIGITS-1:0]      blank;
  logic [NUM_DIGITS-1:0]      digit_sel;
  scan_state_t                state;
  logic                       tc;
  logic                       dead_end;

  refresh_prescaler #(
    .REFRESH_DIV (REFRESH_DIV),
    .DEAD_CYCLES (DEAD_CYCLES)
  ) u_prescaler (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .tc       (tc),
    .dead_end (dead_end)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_val <= '0;
      shadow_dp  <= '0;
    end else if (load) begin
      shadow_val <= value;
      shadow_dp  <= dp_in;
    end
  end

  // A digit above 0 is blanked when it and everything to its left is zero and its dp is off.
  always_comb begin
    nz_at_or_above = '0;
    blank          = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nz_at_or_above[i] = nz_at_or_above[i+1] | (shadow_val[i] != 4'h0);
      blank[i] = (BLANK_LEADING != 0) && (i != 0) && !nz_at_or_above[i] && !shadow_dp[i];
    end
  end

  always_comb begin
    digit_sel            = '0;
    digit_sel[digit_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= DEAD;
      digit_idx <= '0;
      nibble    <= 4'h0;
      anode_n   <= ANODES_OFF;
      dp_n      <= SEG_OFF;
    end else if (!enable) begin
      state   <= DEAD;
      anode_n <= ANODES_OFF;
      dp_n    <= SEG_OFF;
    end else begin
      case (state)
        DEAD: begin
          if (dead_end) begin
            state   <= DRIVE;
            nibble  <= shadow_val[digit_idx];
            anode_n <= blank[digit_idx] ? ANODES_OFF : ~digit_sel;
            dp_n    <= ~shadow_dp[digit_idx];
          end
        end
        DRIVE: begin
          if (tc) begin
            state     <= DEAD;
            anode_n   <= ANODES_OFF;
            dp_n      <= SEG_OFF;
            digit_idx <= (digit_idx == LAST_IDX) ? '0 : digit_idx + IDX_W'(1);
          end
        end
        default: state <= DEAD;
      endcase
    end
  end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Bench for hex_display_scanner: slot-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized loads and enable drops.
module tb_hex_display_scanner;

  localparam int N = 4;
  localparam int R = 8;
  localparam int D = 2;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  nibble;
  logic [3:0]  anode_n;
  logic        dp_n;
  logic [1:0]  digit_idx;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  hex_display_scanner #(
    .NUM_DIGITS    (N),
    .REFRESH_DIV   (R),
    .DEAD_CYCLES   (D),
    .BLANK_LEADING (1)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .load      (load),
    .value     (value),
    .dp_in     (dp_in),
    .nibble    (nibble),
    .anode_n   (anode_n),
    .dp_n      (dp_n),
    .digit_idx (digit_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: position within the slot, current digit, shadow and the
  // values latched when the dead interval of a slot ends.
  logic [15:0] m_sval;
  logic [3:0]  m_sdp;
  logic [3:0]  m_nib;
  logic [3:0]  m_an;
  logic        m_dpn;
  int          m_dig;
  int          m_pos;
  bit          m_paused;

  function automatic logic [3:0] nib_of(input logic [15:0] v, input int d);
    logic [15:0] s;
    s = v >> (4 * d);
    return s[3:0];
  endfunction

  function automatic logic [3:0] lit_anode(input logic [15:0] v, input logic [3:0] dp, input int d);
    logic [15:0] upper;
    logic [3:0]  one;
    upper = v >> (4 * d);
    one   = 4'b0001;
    if (d == 0 || upper != 16'h0 || dp[d]) return ~(one << d);
    return 4'hF;
  endfunction

  function automatic int next_pos(input int pos, input bit paused);
    return (paused ? 0 : pos) + 1;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_sval   <= 16'h0;
      m_sdp    <= 4'h0;
      m_nib    <= 4'h0;
      m_an     <= 4'hF;
      m_dpn    <= 1'b1;
      m_dig    <= 0;
      m_pos    <= 0;
      m_paused <= 1'b0;
    end else begin
      if (enable) begin
        if (next_pos(m_pos, m_paused) == D) begin
          m_nib <= nib_of(m_sval, m_dig);
          m_an  <= lit_anode(m_sval, m_sdp, m_dig);
          m_dpn <= ~m_sdp[m_dig];
        end
        if (next_pos(m_pos, m_paused) == R) begin
          m_pos <= 0;
          m_dig <= (m_dig + 1) % N;
        end else begin
          m_pos <= next_pos(m_pos, m_paused);
        end
        m_paused <= 1'b0;
      end else begin
        m_paused <= 1'b1;
      end
      if (load) begin
        m_sval <= value;
        m_sdp  <= dp_in;
      end
    end
  end

  function automatic logic [3:0] exp_anode();
    return (!m_paused && m_pos >= D) ? m_an : 4'hF;
  endfunction

  function automatic logic exp_dpn();
    return (!m_paused && m_pos >= D) ? m_dpn : 1'b1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, required %0h", nm, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model nibble", nibble, m_nib);
      chk("model anode_n", anode_n, exp_anode());
      chk("model dp_n", dp_n, exp_dpn());
      chk("model digit_idx", digit_idx, m_dig);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
    value   = v;
    dp_in   = dp;
    load    = 1'b1;
    @(negedge clk);
    load    = 1'b0;
  endtask

  // Returns at the first driven cycle of digit d (as the model sees it), bounded.
  task automatic wait_drive(input int d);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (m_dig == d && m_pos == D && !m_paused) ok = 1'b1;
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_drive digit %0d: not reached, required within 100 cycles", d);
    end
  endtask

  task automatic chk_out(input string nm, input logic [3:0] nib, input logic [3:0] an,
                         input logic dpn, input logic [1:0] idx);
    chk({nm, " nibble"}, nibble, nib);
    chk({nm, " anode_n"}, anode_n, an);
    chk({nm, " dp_n"}, dp_n, dpn);
    chk({nm, " digit_idx"}, digit_idx, idx);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] rv;
    int          off_left;
    reset_n = 1'b1;
    enable  = 1'b0;
    load    = 1'b0;
    value   = 16'h0;
    dp_in   = 4'h0;
    off_left = 0;
    #1 reset_n = 1'b0;
    #1 chk_on = 1'b1;
    step(2);
    chk_out("reset", 4'h0, 4'hF, 1'b1, 2'd0);

    // Scenario 1: 1A2F scanned digit by digit
    reset_n = 1'b1;
    value   = 16'h1A2F;
    dp_in   = 4'h0;
    load    = 1'b1;
    enable  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk_out("s1 first dead", 4'h0, 4'hF, 1'b1, 2'd0);
    wait_drive(0);
    chk_out("s1 digit0", 4'hF, 4'b1110, 1'b1, 2'd0);
    step(5);
    chk_out("s1 digit0 last", 4'hF, 4'b1110, 1'b1, 2'd0);
    step(1);
    chk_out("s1 slot1 dead0", 4'hF, 4'hF, 1'b1, 2'd1);
    step(1);
    chk_out("s1 slot1 dead1", 4'hF, 4'hF, 1'b1, 2'd1);
    wait_drive(1);
    chk_out("s1 digit1", 4'h2, 4'b1101, 1'b1, 2'd1);
    wait_drive(2);
    chk_out("s1 digit2", 4'hA, 4'b1011, 1'b1, 2'd2);
    wait_drive(3);
    chk_out("s1 digit3", 4'h1, 4'b0111, 1'b1, 2'd3);
    step(32);
    chk_out("s1 frame repeat", 4'h1, 4'b0111, 1'b1, 2'd3);

    // Scenario 2: leading-zero blanking
    do_load(16'h0005, 4'h0);
    wait_drive(0);
    chk_out("s2 digit0", 4'h5, 4'b1110, 1'b1, 2'd0);
    wait_drive(1);
    chk_out("s2 digit1 blank", 4'h0, 4'hF, 1'b1, 2'd1);
    wait_drive(3);
    chk_out("s2 digit3 blank", 4'h0, 4'hF, 1'b1, 2'd3);
    do_load(16'h0000, 4'h0);
    wait_drive(0);
    chk_out("s2 zero digit0", 4'h0, 4'b1110, 1'b1, 2'd0);

    // Scenario 3: dp keeps a zero digit lit
    do_load(16'h0030, 4'b0100);
    wait_drive(1);
    chk_out("s3 digit1", 4'h3, 4'b1101, 1'b1, 2'd1);
    wait_drive(2);
    chk_out("s3 digit2 dp", 4'h0, 4'b1011, 1'b0, 2'd2);
    wait_drive(3);
    chk_out("s3 digit3 blank", 4'h0, 4'hF, 1'b1, 2'd3);

    // Scenario 4: load mid-slot only takes effect at the next slot
    do_load(16'hABCD, 4'h0);
    wait_drive(0);
    wait_drive(1);
    chk_out("s4 digit1", 4'hC, 4'b1101, 1'b1, 2'd1);
    step(1);
    do_load(16'h1234, 4'h0);
    step(3);
    chk_out("s4 digit1 held", 4'hC, 4'b1101, 1'b1, 2'd1);
    wait_drive(2);
    chk_out("s4 digit2 new", 4'h2, 4'b1011, 1'b1, 2'd2);

    // Scenario 5: enable drop during digit 2
    step(1);
    enable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("s5 frozen anode_n", anode_n, 4'hF);
      chk("s5 frozen digit_idx", digit_idx, 2'd2);
    end
    enable = 1'b1;
    step(1);
    chk_out("s5 resume dead", 4'h2, 4'hF, 1'b1, 2'd2);
    step(1);
    chk_out("s5 resume drive", 4'h2, 4'b1011, 1'b1, 2'd2);

    // Scenario 6: asynchronous reset mid-drive of digit 3
    wait_drive(3);
    chk_out("s6 digit3", 4'h1, 4'b0111, 1'b1, 2'd3);
    step(2);
    #2 reset_n = 1'b0;
    #1 chk_out("s6 async reset", 4'h0, 4'hF, 1'b1, 2'd0);
    step(2);
    reset_n = 1'b1;
    step(1);
    chk_out("s6 restart dead", 4'h0, 4'hF, 1'b1, 2'd0);
    step(1);
    chk_out("s6 restart drive", 4'h0, 4'b1110, 1'b1, 2'd0);

    // Randomized loads, values with leading zeros, dp bits and enable drops
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      load = 1'b0;
      if ($urandom_range(0, 11) == 0) begin
        rv    = 16'($urandom);
        rv    = rv >> (4 * $urandom_range(0, 4));
        value = rv;
        dp_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
        load  = 1'b1;
      end
      if (enable) begin
        if ($urandom_range(0, 59) == 0) begin
          enable   = 1'b0;
          off_left = $urandom_range(1, 12);
        end
      end else begin
        off_left--;
        if (off_left <= 0) enable = 1'b1;
      end
    end
    @(negedge clk);
    load = 1'b0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
